demux13_5_reg: RTL and testbench

//  Registered 1-to-5 distributor: the write-side counterpart of the 5-input datapath selector.

---
 rtl/mux_pkg.sv | 26 ++
 rtl/demux13_5_reg_slot.sv | 43 ++++
 rtl/demux13_5_reg.sv | 104 ++++++++++
 tb/tb_demux13_5_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the 5-way datapath selector and its
// write-side counterpart, the registered 1-to-5 distributor.
package mux_pkg;

  // Width of every routed datapath word.
  localparam int DATA_W = 32;

  // Number of destinations / sources; the datapath is built around exactly five.
  localparam int N_OUT = 5;

  // Selector width; 3 bits covers indices 0..4 with 5..7 left over.
  localparam int SEL_W = 3;

  // Arm taken by the selector when its code is out of range (5..7).
  localparam logic [SEL_W-1:0] SEL_DEFAULT = 3'd0;

  // Highest legal selector code.
  localparam logic [SEL_W-1:0] SEL_MAX = 3'(N_OUT - 1);

  // A single routed datapath word.
  typedef logic [DATA_W-1:0] word_t;

  // A selector code as presented by the producer.
  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/demux13_5_reg_slot.sv
// One destination of the distributor: a single-entry holding register with a
// valid flag. A write and an ack can land in the same cycle, which keeps the
// slot full and gives one word per cycle of throughput.
module demux_slot
  import mux_pkg::*;
#(
  parameter int DATA_W = mux_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid,
  output logic              o_ready
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Hold the routed word; a write always wins, and an ack only empties the slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_wr_en) begin
      r_data  <= i_din;
      r_valid <= 1'b1;
    end else if (i_ack && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  // The slot can take a word when empty or when its content leaves this cycle.
  always_comb begin
    o_ready = !r_valid || i_ack;
  end

  assign o_dout  = r_data;
  assign o_valid = r_valid;

endmodule : demux_slot

// File: rtl/demux13_5_reg.sv
// Registered 1-to-5 distributor. Routes one producer word into one of five
// single-entry holding registers picked by a 3-bit selector. Out-of-range
// selector codes fall back to destination 0 and raise a sticky fault flag.
module demux13_5_reg
  import mux_pkg::*;
#(
  parameter int DATA_W = mux_pkg::DATA_W,
  parameter int N_OUT  = mux_pkg::N_OUT,
  parameter int SEL_W  = mux_pkg::SEL_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [SEL_W-1:0]  i_selector,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_in_ready,
  input  logic              i_ack_0,
  input  logic              i_ack_1,
  input  logic              i_ack_2,
  input  logic              i_ack_3,
  input  logic              i_ack_4,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_data_3,
  output logic [DATA_W-1:0] o_data_4,
  output logic              o_valid_0,
  output logic              o_valid_1,
  output logic              o_valid_2,
  output logic              o_valid_3,
  output logic              o_valid_4,
  output logic              o_sel_fault
);

  logic [N_OUT-1:0]  w_ack;
  logic [N_OUT-1:0]  w_slot_valid;
  logic [N_OUT-1:0]  w_slot_ready;
  logic [N_OUT-1:0]  w_wr_en;
  logic [DATA_W-1:0] w_slot_data [N_OUT];
  logic [SEL_W-1:0]  w_eff_sel;
  logic              w_sel_oob;
  logic              w_accept;
  logic              r_sel_fault;

  assign w_ack = {i_ack_4, i_ack_3, i_ack_2, i_ack_1, i_ack_0};

  // Fold out-of-range selector codes onto the default arm, as the read-side selector does.
  always_comb begin
    w_sel_oob = (i_selector > SEL_W'(N_OUT - 1));
    w_eff_sel = w_sel_oob ? SEL_DEFAULT : i_selector;
  end

  // Ready reflects only the addressed slot; it never looks at in_valid.
  always_comb begin
    o_in_ready = w_slot_ready[0];
    for (int k = 0; k < N_OUT; k++) begin
      if (w_eff_sel == SEL_W'(k)) begin
        o_in_ready = w_slot_ready[k];
      end
    end
  end

  assign w_accept = i_in_valid && o_in_ready;

  // One independent holding register per destination, written only when addressed.
  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign w_wr_en[k] = w_accept && (w_eff_sel == SEL_W'(k));

    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_wr_en (w_wr_en[k]),
      .i_ack   (w_ack[k]),
      .i_din   (i_data_in),
      .o_dout  (w_slot_data[k]),
      .o_valid (w_slot_valid[k]),
      .o_ready (w_slot_ready[k])
    );
  end

  // Remember that a word was ever accepted with an illegal selector, until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel_fault <= 1'b0;
    end else if (w_accept && w_sel_oob) begin
      r_sel_fault <= 1'b1;
    end
  end

  assign o_data_0    = w_slot_data[0];
  assign o_data_1    = w_slot_data[1];
  assign o_data_2    = w_slot_data[2];
  assign o_data_3    = w_slot_data[3];
  assign o_data_4    = w_slot_data[4];
  assign o_valid_0   = w_slot_valid[0];
  assign o_valid_1   = w_slot_valid[1];
  assign o_valid_2   = w_slot_valid[2];
  assign o_valid_3   = w_slot_valid[3];
  assign o_valid_4   = w_slot_valid[4];
  assign o_sel_fault = r_sel_fault;

endmodule : demux13_5_reg

// File: tb/tb_demux13_5_reg.sv
// Bench for the registered 1-to-5 distributor. The driver pushes each word it
// expects to be accepted into a scoreboard queue; a monitor pops and compares
// whenever a slot presents a fresh word.
module tb_demux13_5_reg;

  typedef struct packed {
    logic [2:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  selector;
  logic        inValid;
  logic [31:0] dataIn;
  logic        inReady;
  logic [4:0]  ack;
  logic [31:0] dutData [5];
  logic [4:0]  dutValid;
  logic        selFault;

  exp_t        expQ[$];
  int          nChecks = 0;
  int          nFails  = 0;
  logic [4:0]  prevValid = '0;
  logic [4:0]  prevAck   = '0;

  demux13_5_reg dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_selector  (selector),
    .i_in_valid  (inValid),
    .i_data_in   (dataIn),
    .o_in_ready  (inReady),
    .i_ack_0     (ack[0]),
    .i_ack_1     (ack[1]),
    .i_ack_2     (ack[2]),
    .i_ack_3     (ack[3]),
    .i_ack_4     (ack[4]),
    .o_data_0    (dutData[0]),
    .o_data_1    (dutData[1]),
    .o_data_2    (dutData[2]),
    .o_data_3    (dutData[3]),
    .o_data_4    (dutData[4]),
    .o_valid_0   (dutValid[0]),
    .o_valid_1   (dutValid[1]),
    .o_valid_2   (dutValid[2]),
    .o_valid_3   (dutValid[3]),
    .o_valid_4   (dutValid[4]),
    .o_sel_fault (selFault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by the driver and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's worth of producer inputs just after a rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [31:0] d);
    inValid  = v;
    selector = sel;
    dataIn   = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // A slot shows a fresh word when it turns valid, or stays valid right after an ack.
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (dutValid[k] === 1'b1 && (!prevValid[k] || prevAck[k])) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected word: slot %0d shows 0x%08h, expected none at %0t",
                   k, dutData[k], $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("route dest", 32'(k), 32'(e.dest));
          checkOutput("route data", dutData[k], e.data);
        end
      end
    end
    prevValid = dutValid;
    prevAck   = ack;
  end

  initial begin
    // Reset held two edges while the producer is offering a word that must be dropped.
    reset = 1'b1;
    ack   = '0;
    applyStimulus(1'b1, 3'd2, 32'hCAFE_F00D);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("reset valids", 32'(dutValid), 32'h0);
    for (int k = 0; k < 5; k++) checkOutput("reset data", dutData[k], 32'h0);
    checkOutput("reset sel_fault", 32'(selFault), 32'h0);
    checkOutput("reset in_ready", 32'(inReady), 32'h1);

    // Single word routed to destination 2.
    stepCycle();
    applyStimulus(1'b1, 3'd2, 32'hDEAD_BEEF);
    expQ.push_back('{dest: 3'd2, data: 32'hDEAD_BEEF});
    @(negedge clk);
    checkOutput("route in_ready", 32'(inReady), 32'h1);
    stepCycle();
    applyStimulus(1'b0, 3'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("route valids", 32'(dutValid), 32'h04);

    // Backpressure on a full slot, then release it with an ack in the same cycle.
    stepCycle();
    applyStimulus(1'b1, 3'd2, 32'h0000_1234);
    @(negedge clk);
    checkOutput("stall in_ready", 32'(inReady), 32'h0);
    stepCycle();
    ack[2] = 1'b1;
    expQ.push_back('{dest: 3'd2, data: 32'h0000_1234});
    @(negedge clk);
    checkOutput("stall data held", dutData[2], 32'hDEAD_BEEF);
    checkOutput("ack in_ready", 32'(inReady), 32'h1);
    stepCycle();
    ack[2] = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("post-ack data_2", dutData[2], 32'h0000_1234);

    // Back-to-back stream into destination 4 with the consumer always acking.
    stepCycle();
    ack[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd4, 32'(i + 1));
      expQ.push_back('{dest: 3'd4, data: 32'(i + 1)});
      @(negedge clk);
      checkOutput("stream in_ready", 32'(inReady), 32'h1);
      if (i > 0) checkOutput("stream valid_4", 32'(dutValid[4]), 32'h1);
      stepCycle();
    end
    applyStimulus(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("stream last valid_4", 32'(dutValid[4]), 32'h1);
    checkOutput("stream last data_4", dutData[4], 32'h4);
    stepCycle();
    ack[4] = 1'b0;
    @(negedge clk);
    checkOutput("drained valid_4", 32'(dutValid[4]), 32'h0);
    checkOutput("drained data_4 kept", dutData[4], 32'h4);

    // Out-of-range selector lands in slot 0 and raises the sticky fault; then fill 1 and 3.
    stepCycle();
    applyStimulus(1'b1, 3'd6, 32'hA5A5_A5A5);
    expQ.push_back('{dest: 3'd0, data: 32'hA5A5_A5A5});
    @(negedge clk);
    checkOutput("oob in_ready", 32'(inReady), 32'h1);
    stepCycle();
    applyStimulus(1'b1, 3'd1, 32'h1111_1111);
    expQ.push_back('{dest: 3'd1, data: 32'h1111_1111});
    @(negedge clk);
    checkOutput("oob sel_fault", 32'(selFault), 32'h1);
    stepCycle();
    applyStimulus(1'b1, 3'd3, 32'h3333_3333);
    expQ.push_back('{dest: 3'd3, data: 32'h3333_3333});
    stepCycle();
    applyStimulus(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("sticky sel_fault", 32'(selFault), 32'h1);
    checkOutput("pre-reset valids", 32'(dutValid), 32'h0F);

    // Reset in the middle of traffic wins over a simultaneous ack and accept.
    stepCycle();
    reset  = 1'b1;
    ack[1] = 1'b1;
    applyStimulus(1'b1, 3'd1, 32'h9999_9999);
    stepCycle();
    reset  = 1'b0;
    ack[1] = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("mid reset valids", 32'(dutValid), 32'h0);
    for (int k = 0; k < 5; k++) checkOutput("mid reset data", dutData[k], 32'h0);
    checkOutput("mid reset sel_fault", 32'(selFault), 32'h0);
    checkOutput("mid reset in_ready", 32'(inReady), 32'h1);

    stepCycle();
    @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_demux13_5_reg
